cpu_boot_loader: RTL and testbench
==================================

# cpu_boot_loader

Front-end stage that sits directly upstream of the 16-bit `CPU` core. It accepts a program image as a stream of 16-bit words and writes it into the CPU instruction memory. It then releases the CPU for execution by asserting `CpuRun`, which the top level uses as the CPU's active-low hold/reset. Until a complete, valid image has been loaded, the CPU is held idle.

## Interface
Parameters:
- `DATA_W`, 16, instruction word width; fixed to the CPU word size.
- `ADDR_W`, 8, instruction memory address width; capacity is 2^ADDR_W words; legal range 1..16.

Ports:
- `Clock`, in, 1: the single clock; all state changes on the rising edge.
- `Reset`, in, 1: asynchronous, active-high.
- `Restart`, in, 1: synchronous request to reload; abort or return to length phase.
- `InValid`, in, 1: source holds a valid word on `InData`.
- `InData`, in, DATA_W: image word.
- `InReady`, out, 1: loader accepts a word this cycle; registered.
- `MemWe`, out, 1: instruction memory write strobe, one cycle per word.
- `MemAddr`, out, ADDR_W: write address.
- `MemData`, out, DATA_W: write data.
- `CpuRun`, out, 1: CPU released; 0 holds the CPU in reset.
- `Done`, out, 1: image loaded and CPU running.
- `Error`, out, 1: image rejected; sticky until `Restart` or `Reset`.

## Operation
- Handshake: a word transfers on an edge where `InValid && InReady`. The source must hold `InData` stable while `InValid && !InReady`.
- States: `S_LEN`, `S_LOAD`, `S_CHECK` (only with the macro), `S_RUN`, `S_ERR`. Reset enters `S_LEN`.
- `S_LEN`: the first accepted word is length N.
  - N == 0 or N > 2^ADDR_W goes to `S_ERR`.
  - Otherwise latch N, clear the address counter, and go to `S_LOAD`.
- `S_LOAD`: each accepted word is written to the current address, and the address counter increments.
  - After the Nth word, go to `S_CHECK` if the macro is enabled, else to `S_RUN`.
  - The address counter wraps to 0 only when N == 2^ADDR_W. This is harmless because loading ends at that point.
- `S_RUN`: `CpuRun`=1 and `Done`=1; `InReady`=0. Extra words are not accepted.
- `S_ERR`: `Error`=1, `CpuRun`=0, `InReady`=0.
- `Restart`:
  - From any state, the next state is `S_LEN`, and `CpuRun`, `Done` and `Error` clear.
  - `Restart` wins over a simultaneous handshake. That word is consumed by the handshake but discarded, and no `MemWe` is issued.
- Memory contents are not cleared on `Restart` or `Reset`.

## Timing
- Reset values: `InReady`=0, `MemWe`=0, `MemAddr`=0, `MemData`=0, `CpuRun`=0, `Done`=0, `Error`=0.
- `InReady` rises on the first edge after `Reset` deasserts. It is 1 in `S_LEN`, `S_LOAD` and `S_CHECK`, and updates on the same edge as the state.
- Write latency: a data word accepted at edge k produces `MemWe`=1, `MemAddr`, and `MemData` valid for exactly the cycle after edge k.
- `CpuRun` rises at edge k+1, where k is the last-word edge (or the checksum-word edge). The final memory write therefore completes before the CPU can fetch.
- Throughput: one word per cycle with `InValid` held high. An N-word image takes N+1 cycles, or N+2 with checksum.
- `Reset` mid-load: everything returns to reset values immediately. The partially written memory is left as-is.

## Configuration
- Macro `BOOT_CHECKSUM_EN`.
- Defined:
  - After the N data words, one more word is accepted in `S_CHECK`.
  - It is compared with the 16-bit modulo-2^16 sum of the N data words; the length word is excluded.
  - Match goes to `S_RUN`; mismatch goes to `S_ERR`.
  - The sum clears on entry to `S_LEN`.
- Undefined: no `S_CHECK` state and no accumulator. `S_LOAD` goes straight to `S_RUN`.

## Structure
- Shared package `cpu_boot_pkg`:
  - state encoding constants;
  - `BOOT_DATA_W` = 16;
  - the length-check limit derived from `ADDR_W`.
- Sub-module `boot_csum_acc`: clear/accumulate on accepted data words, with a 16-bit sum output. It is instantiated only under `BOOT_CHECKSUM_EN`.
- All other logic stays in `cpu_boot_loader`.

## Test plan
- Basic load, N=3, words 0x1111, 0x2222, 0x3333:
  - `MemWe` pulses at addresses 0, 1, 2 with matching data;
  - `CpuRun`=`Done`=1 one cycle after the last write;
  - `InReady`=0 afterwards.
- Length 0, then a separate run with length 0x0101 (`ADDR_W`=8):
  - `Error`=1 after the length word, no `MemWe`, `CpuRun` stays 0.
- Full image, N=256: writes cover addresses 0..255, then `CpuRun`=1 with no extra write.
- Backpressure-free gaps, `InValid` toggled every other cycle for N=4: exactly 4 writes at addresses 0..3 with no duplicates.
- `Restart` asserted together with the 2nd data word of N=4:
  - that word is not written;
  - the state returns to `S_LEN`;
  - a fresh N=2 image loads at addresses 0..1.
- With `BOOT_CHECKSUM_EN`, N=2, data 0xFFFF and 0x0002:
  - checksum 0x0001 gives `CpuRun`=1;
  - checksum 0x0002 gives `Error`=1 and `CpuRun`=0.

Source files
------------

// File: rtl/cpu_boot_pkg.sv
// Shared types and constants for the CPU boot loader.
// State encoding, word width and the image length limit used by the length check.
package cpu_boot_pkg;

  localparam int unsigned BOOT_DATA_W = 16;

  typedef enum logic [2:0] {
    S_LEN   = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_RUN   = 3'd3,
    S_ERR   = 3'd4
  } boot_state_e;

  // Largest legal image length: the full instruction memory, 2^aw words.
  function automatic logic [16:0] len_limit(input int unsigned aw);
    return 17'(1) << aw;
  endfunction

endpackage

// File: rtl/cpu_boot_loader_if.sv
// Image stream, instruction memory write port and CPU control of the boot loader.
// The loader uses the slave modport; the image source / system side uses master.
interface cpu_boot_loader_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
);
  logic              Restart;
  logic              InValid;
  logic [DATA_W-1:0] InData;
  logic              InReady;
  logic              MemWe;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemData;
  logic              CpuRun;
  logic              Done;
  logic              Error;

  modport slave (
    input  Restart, InValid, InData,
    output InReady, MemWe, MemAddr, MemData, CpuRun, Done, Error
  );

  modport master (
    output Restart, InValid, InData,
    input  InReady, MemWe, MemAddr, MemData, CpuRun, Done, Error
  );
endinterface

// File: rtl/cpu_boot_loader_csum_acc.sv
// Modulo-2^16 running sum of accepted image data words.
// Instantiated by cpu_boot_loader only when BOOT_CHECKSUM_EN is defined.
module boot_csum_acc
  import cpu_boot_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   acc_i,
  input  logic [BOOT_DATA_W-1:0] data_i,
  output logic [BOOT_DATA_W-1:0] sum_o
);

  logic [BOOT_DATA_W-1:0] sum_d, sum_q;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (acc_i) begin
      sum_d = sum_q + data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/cpu_boot_loader.sv
// Boot loader: streams a length-prefixed image into instruction memory, then releases the CPU.
// Define BOOT_CHECKSUM_EN to require a trailing checksum word before release.
module cpu_boot_loader
  import cpu_boot_pkg::*;
#(
  parameter int unsigned DATA_W = BOOT_DATA_W,
  parameter int unsigned ADDR_W = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  cpu_boot_loader_if.slave   boot_io
);

  localparam logic [16:0] LenLimit = len_limit(ADDR_W);

  boot_state_e       state_q;
  logic              ready_q;
  logic              we_q;
  logic              run_q;
  logic              done_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_q;

  logic accept;
  logic len_bad;

  assign accept  = boot_io.InValid && ready_q;
  assign len_bad = (boot_io.InData == '0) || (32'(boot_io.InData) > 32'(LenLimit));

`ifdef BOOT_CHECKSUM_EN
  logic [BOOT_DATA_W-1:0] csum;

  boot_csum_acc u_csum (
    .clk_i  (Clock),
    .rst_i  (Reset),
    .clr_i  (boot_io.Restart || (state_q == S_LEN)),
    .acc_i  (accept && (state_q == S_LOAD)),
    .data_i (boot_io.InData),
    .sum_o  (csum)
  );
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_LEN;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      run_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      last_q     <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      we_q <= 1'b0;
      if (boot_io.Restart) begin
        // A word handshaken in this cycle is consumed but dropped.
        state_q <= S_LEN;
        ready_q <= 1'b1;
        run_q   <= 1'b0;
        done_q  <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        unique case (state_q)
          S_LEN: begin
            ready_q <= 1'b1;
            if (accept) begin
              if (len_bad) begin
                state_q <= S_ERR;
                ready_q <= 1'b0;
                err_q   <= 1'b1;
              end else begin
                state_q <= S_LOAD;
                last_q  <= ADDR_W'(boot_io.InData - DATA_W'(1));
                addr_q  <= '0;
              end
            end
          end
          S_LOAD: begin
            if (accept) begin
              we_q       <= 1'b1;
              mem_addr_q <= addr_q;
              mem_data_q <= boot_io.InData;
              addr_q     <= addr_q + ADDR_W'(1);
              if (addr_q == last_q) begin
`ifdef BOOT_CHECKSUM_EN
                state_q <= S_CHECK;
`else
                state_q <= S_RUN;
                ready_q <= 1'b0;
`endif
              end
            end
          end
          S_CHECK: begin
`ifdef BOOT_CHECKSUM_EN
            if (accept) begin
              ready_q <= 1'b0;
              if (boot_io.InData == csum) begin
                state_q <= S_RUN;
              end else begin
                state_q <= S_ERR;
                err_q   <= 1'b1;
              end
            end
`else
            state_q <= S_LEN;
`endif
          end
          S_RUN: begin
            // Release one edge after the final accept so the last write lands first.
            ready_q <= 1'b0;
            run_q   <= 1'b1;
            done_q  <= 1'b1;
          end
          S_ERR: begin
            ready_q <= 1'b0;
            run_q   <= 1'b0;
            err_q   <= 1'b1;
          end
          default: begin
            state_q <= S_LEN;
          end
        endcase
      end
    end
  end

  assign boot_io.InReady = ready_q;
  assign boot_io.MemWe   = we_q;
  assign boot_io.MemAddr = mem_addr_q;
  assign boot_io.MemData = mem_data_q;
  assign boot_io.CpuRun  = run_q;
  assign boot_io.Done    = done_q;
  assign boot_io.Error   = err_q;

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Table-driven bench for cpu_boot_loader with a write scoreboard.
// Honours BOOT_CHECKSUM_EN by appending the expected checksum word to each image.
module tb_cpu_boot_loader;
  import cpu_boot_pkg::*;

  localparam int unsigned AW = 8;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  cpu_boot_loader_if #(.DATA_W(16), .ADDR_W(AW)) bif ();

  cpu_boot_loader #(.DATA_W(16), .ADDR_W(AW)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .boot_io (bif)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  typedef struct {
    logic [15:0] len;
    logic [15:0] base;
    logic [15:0] step;
    bit          gap;
    bit          bad;
  } case_t;

  wr_t   exp_q[$];
  case_t cases[6];
  int    n_cmp = 0;
  int    n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One clock: sample ready and check any memory write at the falling edge.
  task automatic tick(output bit rdy);
    wr_t e;
    @(negedge Clock);
    rdy = bif.InReady;
    if (bif.MemWe === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h want none",
                 bif.MemAddr, bif.MemData);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bif.MemAddr), 32'(e.addr));
        chk("wr_data", 32'(bif.MemData), 32'(e.data));
      end
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic cycles(input int n);
    bit r;
    repeat (n) tick(r);
  endtask

  task automatic send(input logic [15:0] w, input bit gap);
    bit r;
    int t;
    t = 0;
    bif.InValid = 1'b1;
    bif.InData  = w;
    do begin
      tick(r);
      t++;
    end while (!r && t < 20);
    if (!r) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got no InReady want accept of %0h", w);
    end
    bif.InValid = 1'b0;
    bif.InData  = 16'($urandom);
    if (gap) cycles(1);
  endtask

  task automatic restart_pulse();
    bif.Restart = 1'b1;
    cycles(1);
    bif.Restart = 1'b0;
    chk("rst_ready", 32'(bif.InReady), 32'd1);
    chk("rst_run",   32'(bif.CpuRun),  32'd0);
    chk("rst_done",  32'(bif.Done),    32'd0);
    chk("rst_err",   32'(bif.Error),   32'd0);
  endtask

  // Sends the data words (length already accepted) and checks release timing.
  task automatic load_image(input int n, input logic [15:0] base, input logic [15:0] step,
                            input bit gap);
    logic [15:0] d;
    logic [15:0] sum;
    sum = '0;
    for (int j = 0; j < n; j++) begin
      d = base + 16'(j) * step;
      sum += d;
      exp_q.push_back(wr_t'{addr: AW'(j), data: d});
`ifdef BOOT_CHECKSUM_EN
      send(d, gap);
`else
      send(d, gap && (j != n - 1));
`endif
    end
`ifdef BOOT_CHECKSUM_EN
    send(sum, 1'b0);
`endif
    chk("run_early", 32'(bif.CpuRun), 32'd0);
    cycles(1);
    chk("run",       32'(bif.CpuRun),  32'd1);
    chk("done",      32'(bif.Done),    32'd1);
    chk("run_ready", 32'(bif.InReady), 32'd0);
    chk("run_err",   32'(bif.Error),   32'd0);
    cycles(2);
    chk("writes_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    cases[0] = '{16'd3,      16'h1111, 16'h1111, 1'b0, 1'b0};
    cases[1] = '{16'd0,      16'h0000, 16'h0000, 1'b0, 1'b1};
    cases[2] = '{16'h0101,   16'h0000, 16'h0000, 1'b0, 1'b1};
    cases[3] = '{16'd256,    16'h0000, 16'h0001, 1'b0, 1'b0};
    cases[4] = '{16'd4,      16'hA5A0, 16'h0001, 1'b1, 1'b0};
    cases[5] = '{16'd1,      16'hBEEF, 16'h0000, 1'b0, 1'b0};

    Reset       = 1'b1;
    bif.Restart = 1'b0;
    bif.InValid = 1'b0;
    bif.InData  = '0;
    cycles(2);
    chk("reset_ready", 32'(bif.InReady), 32'd0);
    chk("reset_we",    32'(bif.MemWe),   32'd0);
    chk("reset_addr",  32'(bif.MemAddr), 32'd0);
    chk("reset_data",  32'(bif.MemData), 32'd0);
    chk("reset_run",   32'(bif.CpuRun),  32'd0);
    chk("reset_done",  32'(bif.Done),    32'd0);
    chk("reset_err",   32'(bif.Error),   32'd0);
    Reset = 1'b0;
    chk("ready_pre", 32'(bif.InReady), 32'd0);
    cycles(1);
    chk("ready_up", 32'(bif.InReady), 32'd1);

    for (int i = 0; i < 6; i++) begin
      restart_pulse();
      send(cases[i].len, cases[i].gap);
      if (cases[i].bad) begin
        cycles(2);
        chk("bad_err",   32'(bif.Error),   32'd1);
        chk("bad_run",   32'(bif.CpuRun),  32'd0);
        chk("bad_ready", 32'(bif.InReady), 32'd0);
        chk("bad_done",  32'(bif.Done),    32'd0);
      end else begin
        load_image(int'(cases[i].len), cases[i].base, cases[i].step, cases[i].gap);
      end
    end

    // Words offered while running are refused.
    bif.InValid = 1'b1;
    bif.InData  = 16'h7777;
    cycles(3);
    bif.InValid = 1'b0;
    chk("run_hold_ready", 32'(bif.InReady), 32'd0);
    chk("run_hold_run",   32'(bif.CpuRun),  32'd1);

    // Restart coinciding with the 2nd data word: that word is dropped.
    restart_pulse();
    send(16'd4, 1'b0);
    exp_q.push_back(wr_t'{addr: AW'(0), data: 16'hC001});
    send(16'hC001, 1'b0);
    begin
      bit r;
      bif.Restart = 1'b1;
      bif.InValid = 1'b1;
      bif.InData  = 16'hC002;
      tick(r);
      chk("restart_hs_ready", 32'(r), 32'd1);
      bif.Restart = 1'b0;
      bif.InValid = 1'b0;
    end
    cycles(2);
    chk("restart_ready", 32'(bif.InReady), 32'd1);
    chk("restart_run",   32'(bif.CpuRun),  32'd0);
    chk("restart_left",  32'(exp_q.size()), 32'd0);
    send(16'd2, 1'b0);
    load_image(2, 16'h5A00, 16'h0100, 1'b0);

`ifdef BOOT_CHECKSUM_EN
    restart_pulse();
    send(16'd2, 1'b0);
    exp_q.push_back(wr_t'{addr: AW'(0), data: 16'hFFFF});
    exp_q.push_back(wr_t'{addr: AW'(1), data: 16'h0002});
    send(16'hFFFF, 1'b0);
    send(16'h0002, 1'b0);
    send(16'h0001, 1'b0);
    cycles(1);
    chk("csum_ok_run", 32'(bif.CpuRun), 32'd1);
    chk("csum_ok_err", 32'(bif.Error),  32'd0);

    restart_pulse();
    send(16'd2, 1'b0);
    exp_q.push_back(wr_t'{addr: AW'(0), data: 16'hFFFF});
    exp_q.push_back(wr_t'{addr: AW'(1), data: 16'h0002});
    send(16'hFFFF, 1'b0);
    send(16'h0002, 1'b0);
    send(16'h0002, 1'b0);
    cycles(2);
    chk("csum_bad_err", 32'(bif.Error),  32'd1);
    chk("csum_bad_run", 32'(bif.CpuRun), 32'd0);
`endif

    // Asynchronous reset in the middle of a load.
    restart_pulse();
    send(16'd5, 1'b0);
    exp_q.push_back(wr_t'{addr: AW'(0), data: 16'h1234});
    send(16'h1234, 1'b0);
    cycles(1);
    Reset = 1'b1;
    #1;
    chk("midrst_ready", 32'(bif.InReady), 32'd0);
    chk("midrst_data",  32'(bif.MemData), 32'd0);
    chk("midrst_run",   32'(bif.CpuRun),  32'd0);
    chk("midrst_we",    32'(bif.MemWe),   32'd0);
    cycles(1);
    Reset = 1'b0;
    cycles(1);
    chk("midrst_ready_up", 32'(bif.InReady), 32'd1);
    chk("final_left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
